// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned multiply/divide sequencer beside ex_stage.
// One operation is accepted from ID/EX. The sequencer then retires one
// operand bit per cycle. The pipeline is stalled until the result is ready,
// and the result is presented for a single cycle on done/result.
//
// Ports
//   clk, rst_n   core clock, asynchronous active-low reset
//   start        ID/EX holds a muldiv op with valid forwarded operands
//   op           00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   op_a, op_b   operands after the forwarding mux
//   kill         flush of the instruction currently in EX
//   stall        freeze IF/ID/EX (combinational)
//   busy         registered, sequencer not idle
//   done         one-cycle result-valid strobe
//   result       product / quotient / remainder, valid while done=1
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       op_q, op_d;
  // acc_hi holds the product high word or the remainder.
  // acc_lo holds the multiplier/product low word or the dividend/quotient.
  logic [XLEN-1:0]  acc_hi_q, acc_hi_d;
  logic [XLEN-1:0]  acc_lo_q, acc_lo_d;
  logic [XLEN-1:0]  opb_q, opb_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic [XLEN:0]    mul_sum;
  logic [XLEN+1:0]  div_trial;
  logic             last_iter;

  always_comb begin
    // The extra bit on the add captures the carry that shifts into hi[MSB].
    mul_sum   = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, opb_q}) : {1'b0, acc_hi_q};
    // Two guard bits make the sign bit (XLEN+1) a clean "trial negative" flag.
    div_trial = {1'b0, acc_hi_q, acc_lo_q[XLEN-1]} - {2'b00, opb_q};
    last_iter = (count_q == CNT_W'(XLEN-1));

    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start && !kill) begin
          op_d    = op;
          opb_d   = op_b;
          count_d = '0;
          if (!op[1]) begin
            acc_hi_d = '0;
            acc_lo_d = op_a;
            state_d  = S_MUL;
          end else if (op_b == '0) begin
            // Divide by zero bypasses iteration.
            // The quotient is all ones and the remainder is the dividend.
            acc_hi_d = op_a;
            acc_lo_d = '1;
            state_d  = S_DONE;
          end else begin
            acc_hi_d = '0;
            acc_lo_d = op_a;
            state_d  = S_DIV;
          end
        end
      end
      S_MUL: begin
        acc_hi_d = mul_sum[XLEN:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[XLEN-1:1]};
        count_d  = count_q + CNT_W'(1);
        if (last_iter) state_d = S_DONE;
      end
      S_DIV: begin
        if (!div_trial[XLEN+1]) acc_hi_d = div_trial[XLEN-1:0];
        else                    acc_hi_d = {acc_hi_q[XLEN-2:0], acc_lo_q[XLEN-1]};
        acc_lo_d = {acc_lo_q[XLEN-2:0], ~div_trial[XLEN+1]};
        count_d  = count_q + CNT_W'(1);
        if (last_iter) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (kill && state_q != S_IDLE) state_d = S_IDLE;

    // Capture the result on entry to DONE.
    // op[0] selects between the hi register (MULHU/REMU) and the lo register (MUL/DIVU).
    if (state_d == S_DONE && state_q != S_DONE)
      result_d = op_d[0] ? acc_hi_d : acc_lo_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      op_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      result_q <= result_d;
    end
  end

  assign stall  = ((state_q == S_IDLE) && start && !kill) ||
                  (((state_q == S_MUL) || (state_q == S_DIV)) && !kill);
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE) && !kill;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        kill;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .kill(kill), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] res;
    int          done_cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model written directly from the operation definitions.
  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: every done pops one expectation and checks value and timing.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got done=1 result=%h expected no done", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("done_cycle", 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  // Pulse start for one cycle. Optionally register the expected response.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit expect_it);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; op = o; op_a = a; op_b = b;
    e.res      = ref_model(o, a, b);
    e.done_cyc = cyc + ((o[1] && b == 0) ? 1 : 33);
    @(negedge clk);
    check("stall_on_start", {31'b0, stall}, 32'd1);
    if (expect_it) sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom;
  endtask

  // Wait for done with a bound.
  // The total stall count includes the start cycle that issue() already checked.
  task automatic wait_done(input int exp_stall);
    int  st;
    bit  seen;
    st = 1; seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
      if (stall) st++;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      check("stall_in_done", {31'b0, stall}, 32'd0);
      check("stall_cycles", 32'(st), 32'(exp_stall));
      @(negedge clk);
      check("busy_after", {31'b0, busy}, 32'd0);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    issue(o, a, b, 1'b1);
    wait_done((o[1] && b == 0) ? 1 : 33);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; op_a = '0; op_b = '0; kill = 1'b0;
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed cases
    run_op(2'b00, 32'd7, 32'd6);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b10, 32'd100, 32'd7);
    run_op(2'b11, 32'd100, 32'd7);
    run_op(2'b10, 32'h8000_0000, 32'd1);
    run_op(2'b10, 32'd5, 32'd0);
    run_op(2'b11, 32'd5, 32'd0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // start together with kill in IDLE is ignored.
    @(posedge clk); #1 start = 1'b1; kill = 1'b1; op = 2'b00; op_a = 32'd3; op_b = 32'd3;
    @(negedge clk);
    check("kill_start_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1 start = 1'b0; kill = 1'b0;
    @(negedge clk);
    check("kill_start_busy", {31'b0, busy}, 32'd0);

    // Kill in the middle of a MUL.
    issue(2'b00, 32'd123, 32'd456, 1'b0);
    repeat (8) @(posedge clk);
    #1 kill = 1'b1;
    @(negedge clk);
    check("kill_mul_stall", {31'b0, stall}, 32'd0);
    check("kill_mul_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1 kill = 1'b0;
    @(negedge clk);
    check("kill_mul_busy", {31'b0, busy}, 32'd0);
    run_op(2'b10, 32'd9, 32'd3);

    // Kill while in DONE suppresses the done strobe.
    issue(2'b10, 32'd5, 32'd0, 1'b0);
    #1 kill = 1'b1;
    @(negedge clk);
    check("kill_done_done", {31'b0, done}, 32'd0);
    check("kill_done_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1 kill = 1'b0;
    @(negedge clk);
    check("kill_done_busy", {31'b0, busy}, 32'd0);

    // Asynchronous reset in the middle of a DIVU.
    issue(2'b10, 32'd1000, 32'd3, 1'b0);
    repeat (13) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_stall", {31'b0, stall}, 32'd0);
    check("arst_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("arst_idle", {31'b0, busy}, 32'd0);
    run_op(2'b00, 32'd12345, 32'd678);
    run_op(2'b00, 32'hDEAD_BEEF, 32'h1234_5678);

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative multiply/divide sequencer sitting beside ex_stage. It accepts one long-latency operation from ID/EX, holds the pipeline with a stall while it iterates one bit per cycle, then presents a 32-bit result for one cycle so EX/MEM can capture it as rd_data. It owns the multi-cycle schedule; the single-cycle ALU in ex_stage is untouched.

Parameters:
XLEN, 32, operand/result width
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
start  in  1  ID/EX holds a muldiv op with forwarded operands valid
op  in  2  00 MUL (low word), 01 MULHU (high word, unsigned), 10 DIVU, 11 REMU
op_a  in  XLEN  operand A (after forwarding mux)
op_b  in  XLEN  operand B (after forwarding mux)
kill  in  1  flush of the instruction in EX (branch/exception)
stall  out  1  freeze IF/ID/EX; combinational
busy  out  1  registered, state != IDLE
done  out  1  one-cycle result-valid strobe
result  out  XLEN  product/quotient/remainder, valid when done=1

Behaviour:
- Reset (async, rst_n=0): state=IDLE, count=0, done=0, busy=0, result=0, internal acc/operand regs=0. Takes effect mid-operation; no done follows.
- States: IDLE, MUL, DIV, DONE.
- IDLE: start=1 & kill=0 -> latch op, operands; op[1]=0 -> MUL, op[1]=1 -> DIV; count=0. start with kill=1 ignored.
- Divide by zero (op[1]=1, op_b=0): IDLE -> DONE directly; DIVU result 0xFFFFFFFF, REMU result = op_a.
- MUL: 2*XLEN-bit product reg {hi,lo}, lo initialised to op_a, hi=0; per cycle: if lo[0], hi+=mcand (XLEN+1-bit add with carry); shift {carry,hi,lo} right 1. count++; after XLEN iterations (count==XLEN-1 on the edge) -> DONE.
- DIV: restoring, unsigned; rem=0, quo=op_a; per cycle: trial = {rem,quo[MSB]} - divisor; if non-negative rem=trial[XLEN-1:0], shift 1 into quo, else shift 0. After XLEN iterations -> DONE.
- DONE: done=1, result driven from registers per latched op (MUL lo, MULHU hi, DIVU quo, REMU rem); unconditionally -> IDLE next edge. start in DONE ignored (the EX instruction is the one completing).
- Latency: start accepted at edge 0; done high in the cycle after edge XLEN+1 (33rd cycle after start for XLEN=32); div-by-zero: done in cycle after edge 1.
- stall = (state==IDLE & start & !kill) | state==MUL | state==DIV. stall=0 in DONE so EX/MEM captures result on the same edge.
- kill in MUL/DIV/DONE: -> IDLE next edge, done forced 0 that cycle, stall=0 that cycle.
- result held at last value when done=0; not checked by consumers.
- start in MUL/DIV ignored (pipeline is stalled, same instruction).
- All arithmetic unsigned, mod 2^XLEN except MULHU high word; no overflow flags.

Test Plan:
- MUL 7*6: start one cycle -> stall high 33 cycles from start, done once with result=42, busy low after.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> result 0xFFFFFFFE; MUL same operands -> 0x00000001.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0x80000000/1 -> 0x80000000; done after 33 cycles.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, done in cycle 2 (after edge 1), stall only one cycle.
- kill at cycle 10 of a MUL -> state IDLE next edge, no done, stall drops; immediate new start DIVU 9/3 -> 3 with full latency.
- rst_n low at cycle 15 of DIVU -> all outputs 0 asynchronously, no done after release; back-to-back MUL after reset -> correct result.
